// File: rtl/drone_seq_pkg.sv
// Shared types and helpers for the drone command sequencer.
package drone_seq_pkg;

  localparam int NUM_MOTORS = 4;

  typedef logic signed [NUM_MOTORS-1:0][15:0] motor_vec_t;
  typedef logic [1:0][2:0] dir_vec_t;

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    SETTLE,
    DONE
  } seq_state_t;

  // Magnitude of a - b, computed at 17 bits so no 16-bit pair can overflow.
  function automatic logic [16:0] abs_diff(input logic signed [15:0] a,
                                           input logic signed [15:0] b);
    logic signed [16:0] d;
    d = {a[15], a} - {b[15], b};
    if (d[16]) begin
      return 17'(-d);
    end else begin
      return 17'(d);
    end
  endfunction

endpackage

// File: rtl/drone_cmd_sequencer_if.sv
// Bundle of the request/response handshakes and the drone_top command and
// feedback signals. The sequencer uses the slave view; the host side
// (command source plus drone model) uses the master view.
interface drone_cmd_sequencer_if;
  import drone_seq_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_altcmd;
  dir_vec_t          req_dircmd;
  motor_vec_t        req_rpm_sense_set;

  logic [2:0]        altcmd;
  dir_vec_t          dircmd;
  motor_vec_t        rpm_sense_set;
  logic              set;
  motor_vec_t        mot_set;
  motor_vec_t        rpm_sense;

  logic              rsp_valid;
  logic              rsp_ready;
  motor_vec_t        rsp_mot_set;
  motor_vec_t        rsp_rpm_sense;
  logic              rsp_timeout;
  logic [15:0]       rsp_settle_cycles;

  modport slave (
    input  req_valid, req_altcmd, req_dircmd, req_rpm_sense_set,
    input  mot_set, rpm_sense, rsp_ready,
    output req_ready, altcmd, dircmd, rpm_sense_set, set,
    output rsp_valid, rsp_mot_set, rsp_rpm_sense, rsp_timeout, rsp_settle_cycles
  );

  modport master (
    output req_valid, req_altcmd, req_dircmd, req_rpm_sense_set,
    output mot_set, rpm_sense, rsp_ready,
    input  req_ready, altcmd, dircmd, rpm_sense_set, set,
    input  rsp_valid, rsp_mot_set, rsp_rpm_sense, rsp_timeout, rsp_settle_cycles
  );

endinterface

// File: rtl/drone_settle_detect.sv
// Tracks how many consecutive cycles every motor set-point has stayed within
// TOL of its previous value. The first settle cycle only primes the history.
module drone_settle_detect
  import drone_seq_pkg::*;
#(
  parameter logic [15:0] TOL = 16'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  input  motor_vec_t  mot_set,
  output logic [15:0] stable_cnt_next
);

  motor_vec_t  prev;
  logic [15:0] stable_cnt;
  logic        all_in_tol;

  // Compare every motor against its previous sample; any excursion restarts the run.
  always_comb begin
    all_in_tol = 1'b1;
    for (int i = 0; i < NUM_MOTORS; i++) begin
      if (abs_diff(mot_set[i], prev[i]) > {1'b0, TOL}) begin
        all_in_tol = 1'b0;
      end
    end
    stable_cnt_next = all_in_tol ? stable_cnt + 16'd1 : 16'd0;
  end

  // History register and stability run length.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev       <= '0;
      stable_cnt <= '0;
    end else if (clear) begin
      prev       <= mot_set;
      stable_cnt <= '0;
    end else if (enable) begin
      prev       <= mot_set;
      stable_cnt <= stable_cnt_next;
    end
  end

endmodule

// File: rtl/drone_cmd_sequencer.sv
// Runs one drone_top command transaction: latch the command, hold set high
// for SET_CYCLES, then wait until mot_set is stable (or the settle limit is
// reached) and present the captured result until the consumer takes it.
module drone_cmd_sequencer
  import drone_seq_pkg::*;
#(
  parameter int unsigned SET_CYCLES    = 10,
  parameter int unsigned STABLE_CYCLES = 8,
  parameter int unsigned MAX_SETTLE    = 100,
  parameter logic [15:0] TOL           = 16'd0
) (
  input logic                  clk,
  input logic                  reset,
  drone_cmd_sequencer_if.slave bus
);

  seq_state_t  state;
  logic [7:0]  apply_cnt;
  logic [15:0] settle_cnt;
  logic [15:0] settle_cnt_next;
  logic [15:0] stable_cnt_next;
  logic        settle_first;
  logic        detect_clear;
  logic        detect_enable;
  logic        is_stable;
  logic        is_timeout;

  // settle_cnt is zeroed on entry to SETTLE, so zero marks the priming cycle.
  assign settle_first    = (settle_cnt == 16'd0);
  assign detect_clear    = (state == SETTLE) && settle_first;
  assign detect_enable   = (state == SETTLE) && !settle_first;
  assign settle_cnt_next = settle_cnt + 16'd1;
  assign is_stable       = (stable_cnt_next == 16'(STABLE_CYCLES));
  assign is_timeout      = (settle_cnt_next == 16'(MAX_SETTLE));

  drone_settle_detect #(
    .TOL(TOL)
  ) u_settle_detect (
    .clk            (clk),
    .reset          (reset),
    .clear          (detect_clear),
    .enable         (detect_enable),
    .mot_set        (bus.mot_set),
    .stable_cnt_next(stable_cnt_next)
  );

  // Transaction FSM with every output registered; reset aborts any transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                 <= IDLE;
      apply_cnt             <= '0;
      settle_cnt            <= '0;
      bus.req_ready         <= 1'b0;
      bus.altcmd            <= '0;
      bus.dircmd            <= '0;
      bus.rpm_sense_set     <= '0;
      bus.set               <= 1'b0;
      bus.rsp_valid         <= 1'b0;
      bus.rsp_mot_set       <= '0;
      bus.rsp_rpm_sense     <= '0;
      bus.rsp_timeout       <= 1'b0;
      bus.rsp_settle_cycles <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            bus.altcmd        <= bus.req_altcmd;
            bus.dircmd        <= bus.req_dircmd;
            bus.rpm_sense_set <= bus.req_rpm_sense_set;
            bus.set           <= 1'b1;
            bus.req_ready     <= 1'b0;
            apply_cnt         <= 8'd1;
            state             <= APPLY;
          end else begin
            bus.req_ready <= 1'b1;
          end
        end
        APPLY: begin
          if (apply_cnt == 8'(SET_CYCLES)) begin
            bus.set    <= 1'b0;
            settle_cnt <= '0;
            state      <= SETTLE;
          end else begin
            apply_cnt <= apply_cnt + 8'd1;
          end
        end
        SETTLE: begin
          if (settle_first) begin
            settle_cnt <= 16'd1;
          end else begin
            settle_cnt <= settle_cnt_next;
            if (is_stable || is_timeout) begin
              bus.rsp_mot_set       <= bus.mot_set;
              bus.rsp_rpm_sense     <= bus.rpm_sense;
              bus.rsp_timeout       <= !is_stable;
              bus.rsp_settle_cycles <= settle_cnt_next;
              bus.rsp_valid         <= 1'b1;
              state                 <= DONE;
            end
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_drone_cmd_sequencer.sv
// Directed bench for drone_cmd_sequencer with TOL=1 so that a +/-1 toggle
// counts as stable and a +/-2 toggle does not.
module tb_drone_cmd_sequencer;
  import drone_seq_pkg::*;

  localparam int          SET_CYCLES    = 10;
  localparam int          STABLE_CYCLES = 8;
  localparam int          MAX_SETTLE    = 100;
  localparam logic [15:0] TOL           = 16'd1;
  localparam int          BUDGET        = 200;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   mode = 0;
  int   amp = 0;
  int   high_cnt;

  always #5 clk = ~clk;

  drone_cmd_sequencer_if bus();

  drone_cmd_sequencer #(
    .SET_CYCLES   (SET_CYCLES),
    .STABLE_CYCLES(STABLE_CYCLES),
    .MAX_SETTLE   (MAX_SETTLE),
    .TOL          (TOL)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  // mot_set seen at edge c+1: mode 0 constant, 1 toggles by amp, 2 steps by 100 at c>=14
  function automatic motor_vec_t pattern(input int m, input int c, input int a);
    motor_vec_t v;
    int delta;
    int base;
    delta = 0;
    if (m == 1 && (c % 2 != 0)) delta = a;
    else if (m == 2 && c >= 14) delta = 100;
    for (int i = 0; i < NUM_MOTORS; i++) begin
      case (i)
        0:       base = 500;
        1:       base = -1000;
        2:       base = 32000;
        default: base = 0;
      endcase
      v[i] = 16'(base + delta);
    end
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    bus.mot_set = pattern(mode, cyc, amp);
  endtask

  task automatic applyStimulus(input logic [2:0] alt, input dir_vec_t dir,
                               input motor_vec_t rss, input motor_vec_t rpm);
    bus.req_altcmd        = alt;
    bus.req_dircmd        = dir;
    bus.req_rpm_sense_set = rss;
    bus.rpm_sense         = rpm;
    bus.req_valid         = 1'b1;
  endtask

  // Accept edge is cyc 0; set falls at edge SET_CYCLES; rsp_valid is
  // registered at edge SET_CYCLES + settle cycles.
  task automatic run_txn(input string name, input int m, input int a,
                         input logic [2:0] alt, input dir_vec_t dir,
                         input motor_vec_t rss, input motor_vec_t rpm,
                         input bit exp_timeout, input int exp_cycles,
                         input bit keep_valid);
    int set_cnt;
    int exp_rise;
    mode = m;
    amp  = a;
    cyc  = -1;
    bus.mot_set = pattern(m, -1, a);
    applyStimulus(alt, dir, rss, rpm);
    step();
    if (!keep_valid) bus.req_valid = 1'b0;
    checkOutput({name, " accept set"}, bus.set, 1);
    checkOutput({name, " accept req_ready"}, bus.req_ready, 0);
    checkOutput({name, " cmd alt/dir"}, {bus.altcmd, bus.dircmd}, {alt, dir});
    checkOutput({name, " cmd rpm_sense_set"}, bus.rpm_sense_set, rss);
    set_cnt = 1;
    while (!bus.rsp_valid && cyc < BUDGET) begin
      step();
      if (bus.set) set_cnt++;
    end
    exp_rise = SET_CYCLES + exp_cycles;
    checkOutput({name, " set high cycles"}, set_cnt, SET_CYCLES);
    checkOutput({name, " rsp_valid rise cycle"}, cyc, exp_rise);
    checkOutput({name, " rsp_valid"}, bus.rsp_valid, 1);
    checkOutput({name, " rsp_timeout"}, bus.rsp_timeout, exp_timeout);
    checkOutput({name, " rsp_settle_cycles"}, bus.rsp_settle_cycles, exp_cycles);
    checkOutput({name, " rsp_mot_set"}, bus.rsp_mot_set, pattern(m, exp_rise - 1, a));
    checkOutput({name, " rsp_rpm_sense"}, bus.rsp_rpm_sense, rpm);
  endtask

  task automatic handshake(input string name, input logic [2:0] alt, input dir_vec_t dir);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    checkOutput({name, " hs rsp_valid"}, bus.rsp_valid, 0);
    checkOutput({name, " hs req_ready"}, bus.req_ready, 1);
    checkOutput({name, " hs cmd retained"}, {bus.altcmd, bus.dircmd}, {alt, dir});
  endtask

  initial begin
    bus.req_valid         = 1'b0;
    bus.req_altcmd        = '0;
    bus.req_dircmd        = '0;
    bus.req_rpm_sense_set = '0;
    bus.rpm_sense         = '0;
    bus.rsp_ready         = 1'b0;
    bus.mot_set           = '0;

    // Reset state
    step();
    step();
    checkOutput("reset req_ready", bus.req_ready, 0);
    checkOutput("reset set", bus.set, 0);
    checkOutput("reset rsp_valid", bus.rsp_valid, 0);
    checkOutput("reset cmd", {bus.altcmd, bus.dircmd}, 0);
    checkOutput("reset rsp_settle_cycles", bus.rsp_settle_cycles, 0);
    reset = 1'b0;
    #1;
    checkOutput("release req_ready before edge", bus.req_ready, 0);
    step();
    checkOutput("idle req_ready", bus.req_ready, 1);
    checkOutput("idle set", bus.set, 0);

    // Constant mot_set: settles after 1 priming + 8 stable cycles
    run_txn("const", 0, 0, 3'd5, {3'd2, 3'd6},
            {16'sd40, 16'sd30, -16'sd20, 16'sd10},
            {16'sd4, -16'sd3, 16'sd2, 16'sd1}, 1'b0, 9, 1'b0);
    handshake("const", 3'd5, {3'd2, 3'd6});

    // Toggle by 2 exceeds TOL=1: timeout at the settle limit
    run_txn("tog2", 1, 2, 3'd3, {3'd1, 3'd7},
            {16'sd1, 16'sd2, 16'sd3, 16'sd4},
            {16'sd100, 16'sd200, -16'sd300, 16'sd400}, 1'b1, 100, 1'b0);
    handshake("tog2", 3'd3, {3'd1, 3'd7});

    // Toggle by 1 is within TOL=1: behaves like constant
    run_txn("tog1", 1, 1, 3'd6, {3'd4, 3'd0},
            {-16'sd7, 16'sd8, 16'sd9, 16'sd10},
            {16'sd11, 16'sd22, 16'sd33, 16'sd44}, 1'b0, 9, 1'b0);
    handshake("tog1", 3'd6, {3'd4, 3'd0});

    // Single change at settle cycle 5 restarts the stable run
    run_txn("step", 2, 0, 3'd1, {3'd5, 3'd3},
            {16'sd5, 16'sd6, 16'sd7, 16'sd8},
            {-16'sd1, -16'sd2, -16'sd3, -16'sd4}, 1'b0, 13, 1'b0);
    handshake("step", 3'd1, {3'd5, 3'd3});

    // req_valid held high throughout; response stalled for 5 cycles
    run_txn("stall", 0, 0, 3'd2, {3'd3, 3'd1},
            {16'sd12, 16'sd13, 16'sd14, 16'sd15},
            {16'sd9, 16'sd8, 16'sd7, 16'sd6}, 1'b0, 9, 1'b1);
    bus.req_altcmd = 3'd7;
    bus.req_dircmd = {3'd6, 3'd5};
    for (int k = 0; k < 5; k++) begin
      step();
      checkOutput("stall rsp_valid", bus.rsp_valid, 1);
      checkOutput("stall rsp_settle_cycles", bus.rsp_settle_cycles, 9);
      checkOutput("stall rsp_mot_set", bus.rsp_mot_set, pattern(0, 0, 0));
      checkOutput("stall req_ready", bus.req_ready, 0);
      checkOutput("stall set", bus.set, 0);
      checkOutput("stall cmd", {bus.altcmd, bus.dircmd}, {3'd2, 3'd3, 3'd1});
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    checkOutput("stall hs rsp_valid", bus.rsp_valid, 0);
    checkOutput("stall hs req_ready", bus.req_ready, 1);
    checkOutput("stall hs set", bus.set, 0);
    step();
    bus.req_valid = 1'b0;
    checkOutput("second accept set", bus.set, 1);
    checkOutput("second accept req_ready", bus.req_ready, 0);
    checkOutput("second accept cmd", {bus.altcmd, bus.dircmd}, {3'd7, 3'd6, 3'd5});
    high_cnt = 0;
    while (!bus.rsp_valid && high_cnt < BUDGET) begin
      step();
      high_cnt++;
    end
    checkOutput("second rsp_settle_cycles", bus.rsp_settle_cycles, 9);
    checkOutput("second rsp_timeout", bus.rsp_timeout, 0);
    handshake("second", 3'd7, {3'd6, 3'd5});

    // Reset during APPLY aborts: set drops without a clock edge
    mode = 0;
    applyStimulus(3'd4, {3'd2, 3'd2}, {16'sd1, 16'sd1, 16'sd1, 16'sd1},
                  {16'sd3, 16'sd3, 16'sd3, 16'sd3});
    step();
    bus.req_valid = 1'b0;
    step();
    step();
    checkOutput("abort pre-reset set", bus.set, 1);
    reset = 1'b1;
    #1;
    checkOutput("abort set", bus.set, 0);
    checkOutput("abort rsp_valid", bus.rsp_valid, 0);
    checkOutput("abort req_ready", bus.req_ready, 0);
    checkOutput("abort cmd cleared", {bus.altcmd, bus.dircmd}, 0);
    step();
    step();
    reset = 1'b0;
    high_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (bus.rsp_valid || bus.set) high_cnt++;
    end
    checkOutput("abort no response", high_cnt, 0);
    run_txn("after_reset", 0, 0, 3'd6, {3'd1, 3'd1},
            {16'sd2, 16'sd4, 16'sd6, 16'sd8},
            {16'sd5, 16'sd5, -16'sd5, 16'sd5}, 1'b0, 9, 1'b0);
    handshake("after_reset", 3'd6, {3'd1, 3'd1});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/drone_cmd_sequencer.md
Name: drone_cmd_sequencer

Overview:
- Hardware sequencer for one drone_top command transaction: accept a command, drive it with set held high, release set, wait for mot_set to settle, return the sampled result.
- Sits between a command source (host/transactor FIFO) and drone_top; it owns the altcmd/dircmd/rpm_sense_set/set inputs of drone_top.
- Settling is detected from motor-set stability, with a timeout, instead of a fixed wait.

Parameters:
- SET_CYCLES, 10, number of cycles set is held high (1..255)
- STABLE_CYCLES, 8, consecutive in-tolerance cycles that count as settled (1..MAX_SETTLE-1)
- MAX_SETTLE, 100, settle-phase cycle limit before timeout (2..65535)
- TOL, 0, max per-motor abs change in mot_set, cycle to cycle, that counts as stable (unsigned, 16 b)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  command request valid
- req_ready  out  1  sequencer can accept a command
- req_altcmd  in  3  altitude command
- req_dircmd  in  [1:0][2:0]  direction commands
- req_rpm_sense_set  in  signed [3:0][15:0]  initial rpm sense values
- altcmd  out  3  to drone_top
- dircmd  out  [1:0][2:0]  to drone_top
- rpm_sense_set  out  signed [3:0][15:0]  to drone_top
- set  out  1  to drone_top; breaks the feedback loop while high
- mot_set  in  signed [3:0][15:0]  from drone_top
- rpm_sense  in  signed [3:0][15:0]  from drone_top
- rsp_valid  out  1  result valid
- rsp_ready  in  1  result consumer ready
- rsp_mot_set  out  signed [3:0][15:0]  captured mot_set
- rsp_rpm_sense  out  signed [3:0][15:0]  captured rpm_sense
- rsp_timeout  out  1  settle limit reached without stability
- rsp_settle_cycles  out  16  settle-phase cycles consumed

Behaviour:
- Reset (async assert, sync use after deassert): state IDLE; all outputs 0. req_ready=1 only after reset deasserts and state is IDLE.
- Reset mid-transaction aborts the transaction. No response is produced; set drops to 0 immediately.
- FSM states: IDLE, APPLY, SETTLE, DONE. All outputs are registered.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: register req_* onto altcmd/dircmd/rpm_sense_set, set<=1, go to APPLY.
  - req_ready=0 in every other state.
- APPLY:
  - set stays 1 for exactly SET_CYCLES cycles, counted from the first cycle it is high.
  - Then set<=0 and go to SETTLE.
- SETTLE, first cycle:
  - prev<=mot_set, settle_cnt<=1, stable_cnt<=0.
- SETTLE, each later cycle:
  - settle_cnt_next = settle_cnt+1.
  - For each motor: d = 17-bit signed mot_set[i]-prev[i]; in_tol if |d| <= TOL.
  - All four in_tol: stable_cnt_next = stable_cnt+1; otherwise stable_cnt_next = 0.
  - prev<=mot_set.
- SETTLE exit:
  - If stable_cnt_next == STABLE_CYCLES: go to DONE, rsp_timeout=0.
  - Else if settle_cnt_next == MAX_SETTLE: go to DONE, rsp_timeout=1.
  - If both hold on the same cycle, stability wins.
  - On exit, capture mot_set, rpm_sense and rsp_settle_cycles=settle_cnt_next into the rsp_* registers.
- DONE:
  - rsp_valid=1; rsp_* held stable until rsp_ready.
  - On rsp_valid&&rsp_ready: rsp_valid<=0, go to IDLE.
- Command outputs (altcmd/dircmd/rpm_sense_set) retain the last accepted command until the next accept, so the drone keeps its closed-loop command.
- No back-to-back accept: a new command can be accepted no earlier than the cycle after the response handshake.

Decomposition:
- Package drone_seq_pkg:
  - seq_state_t enum (IDLE, APPLY, SETTLE, DONE)
  - typedefs motor_vec_t = logic signed [3:0][15:0] and dir_vec_t = logic [1:0][2:0]
  - NUM_MOTORS=4
- Sub-module drone_settle_detect:
  - Holds prev, the per-motor tolerance compare and stable_cnt.
  - Ports: clk, reset, clear, enable, mot_set, stable_cnt_next out.
  - The FSM and timeout counter stay in drone_cmd_sequencer.

Test Plan:
- Constant mot_set=4x16'd500, accept at edge 0 -> set high cycles 1..10; rsp_valid rises at cycle 20; rsp_settle_cycles=9, rsp_timeout=0, rsp_mot_set=500s.
- mot_set toggles 500/501 every cycle, TOL=0 -> rsp_timeout=1, rsp_settle_cycles=100.
- Same toggle with TOL=1 -> rsp_timeout=0, rsp_settle_cycles=9.
- mot_set changes once at settle cycle 5, then constant -> stable_cnt restarts; rsp_settle_cycles=13.
- req_valid held high during a transaction, rsp_ready held low 5 cycles -> only one accept; rsp_* stable while stalled; second accept on the cycle after the handshake.
- reset asserted during APPLY -> set=0 immediately, no rsp_valid; next command after release runs a full sequence.
